mandel_iter: RTL and testbench
==============================

MANDEL_ITER -- requirements
Module: mandel_iter

Interface
REQ-001 SHALL have parameter ITER_W, default 8, meaning the iteration counter width.
REQ-002 SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port c_re, input, 32 bits: real part of c, signed fixed point with 21 fraction bits (Q10.21), as produced by the pixel-to-plane mapper.
REQ-005 SHALL have port c_im, input, 32 bits: imaginary part of c, Q10.21.
REQ-006 SHALL have port px_x / px_y, input, 10 bits each: pixel tag, passed through unchanged.
REQ-007 SHALL have port max_iter, input, ITER_W bits: iteration limit, sampled at accept.
REQ-008 SHALL have port in_valid, input, 1 bit, and port in_ready, output, 1 bit: input handshake.
REQ-009 SHALL have ports out_count (output, ITER_W bits), out_inside (output, 1 bit) and out_x / out_y (output, 10 bits each): the result.
REQ-010 SHALL have port out_valid, output, 1 bit, and port out_ready, input, 1 bit: output handshake.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, ITER, DONE.
REQ-012 SHALL drive in_ready high only in IDLE; this is combinational from state.
REQ-013 SHALL accept on in_valid && in_ready, latching c, tag and max_iter, clearing z_re, z_im and iter to 0, and moving to ITER.
REQ-014 SHALL, in each ITER cycle, compute zr2=z_re*z_re, zi2=z_im*z_im and zri=z_re*z_im from the current z.
REQ-015 SHALL treat every product as a 64-bit signed product, arithmetic-shifted right 21 and truncated to 32 bits, with no saturation.
REQ-016 SHALL define escape as the 33-bit signed sum zr2+zi2 being strictly greater than 4.0 (0x0080_0000); equal to 4.0 is not an escape.
REQ-017 SHALL, in ITER, go to DONE with count=iter and inside=0 on escape; otherwise, if iter==max_iter, go to DONE with count=iter and inside=1.
REQ-018 SHALL, in ITER with neither escape nor the limit reached, update z_re<=zr2-zi2+c_re, z_im<=(zri<<1)+c_im, iter<=iter+1.
REQ-019 SHALL assert out_valid throughout DONE, and only in DONE; out_count, out_inside, out_x and out_y are held stable while out_valid is high.
REQ-020 SHALL complete the output transfer on out_valid && out_ready and go to IDLE; a new input cannot be accepted in that same cycle.
REQ-021 SHALL raise out_valid after exactly count+1 rising edges following the accept edge.
REQ-022 SHALL, with max_iter=0, produce count=0 and inside=1 one edge after accept.
REQ-023 SHALL ignore in_valid outside IDLE and hold the latched inputs against changes on the input ports.

Reset
REQ-024 SHALL, on rst, go to IDLE and clear z, iter, latched c/tag, out_count, out_x, out_y, out_inside and out_valid to 0.
REQ-025 SHALL, on rst in ITER or DONE, discard the job with no output transfer; in_ready is high on the first cycle after rst is released.

Configuration
REQ-026 SHALL, with MANDEL_ZOUT_EN defined, add output ports z_re_out and z_im_out (32 bits each) carrying the final z, stable in DONE and reset to 0.
REQ-027 SHALL, with MANDEL_ZOUT_EN undefined, have no such ports and no extra registers; all other behaviour is identical.

Structure
REQ-028 SHALL take WIDTH=32, FRAC_BITS=21, ESCAPE_R2=32'h0080_0000 and the FSM state enum from shared package mandel_pkg.
REQ-029 SHALL use sub-module fxp_mul (combinational Q10.21 multiply per REQ-015), instantiated three times.

Verification
REQ-030 SHALL be verified with c=(0,0), max_iter=255 -> count=255, inside=1, out_valid 256 edges after accept.
REQ-031 SHALL be verified with c=(0x0050_0000 [2.5], 0) -> count=1, inside=0, out_valid 2 edges after accept.
REQ-032 SHALL be verified with c=(0xFFC0_0000 [-2.0], 0), max_iter=20 -> |z|^2 settles at exactly 4.0, giving no escape, count=20, inside=1.
REQ-033 SHALL be verified with max_iter=0 and any c -> count=0, inside=1 one edge after accept, and in_ready low until after the transfer.
REQ-034 SHALL be verified with out_ready held low 5 cycles in DONE -> out_valid and outputs stable, in_ready low, and input changes ignored.
REQ-035 SHALL be verified with rst pulsed mid-ITER (c=0, max_iter=100) -> out_valid never rises, in_ready is 1 the cycle after release, and the next job is correct.

Source files
------------

// File: rtl/mandel_pkg.sv
// mandel_pkg: shared fixed-point constants and FSM state type for the Mandelbrot iterator
package mandel_pkg;
  localparam int WIDTH = 32;
  localparam int FRAC_BITS = 21;
  localparam logic [WIDTH-1:0] ESCAPE_R2 = 32'h0080_0000;
  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
endpackage

// File: rtl/fxp_mul.sv
// fxp_mul: combinational Q10.21 signed multiply, 64-bit product arithmetic-shifted and truncated
module fxp_mul
  import mandel_pkg::*;
(
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] p
);
  logic signed [2*WIDTH-1:0] full;
  assign full = a * b;
  assign p = WIDTH'(full >>> FRAC_BITS);
endmodule

// File: rtl/mandel_iter.sv
// mandel_iter: Mandelbrot escape-time iterator, IDLE/ITER/DONE handshake FSM (MANDEL_ZOUT_EN adds z_re_out/z_im_out)
module mandel_iter
  import mandel_pkg::*;
#(
  parameter int ITER_W = 8
) (
  input  logic              clock,
  input  logic              rst,
  input  logic [WIDTH-1:0]  c_re,
  input  logic [WIDTH-1:0]  c_im,
  input  logic [9:0]        px_x,
  input  logic [9:0]        px_y,
  input  logic [ITER_W-1:0] max_iter,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ITER_W-1:0] out_count,
  output logic              out_inside,
  output logic [9:0]        out_x,
  output logic [9:0]        out_y,
  output logic              out_valid,
  input  logic              out_ready
`ifdef MANDEL_ZOUT_EN
  ,
  output logic [WIDTH-1:0]  z_re_out,
  output logic [WIDTH-1:0]  z_im_out
`endif
);
  state_t state;
  logic signed [WIDTH-1:0] z_re, z_im, cr, ci, zr2, zi2, zri;
  logic signed [WIDTH:0] mag;
  logic [ITER_W-1:0] iter, mi;
  logic esc;
  fxp_mul u_rr (.a(z_re), .b(z_re), .p(zr2));
  fxp_mul u_ii (.a(z_im), .b(z_im), .p(zi2));
  fxp_mul u_ri (.a(z_re), .b(z_im), .p(zri));
  assign mag = {zr2[WIDTH-1], zr2} + {zi2[WIDTH-1], zi2};
  assign esc = mag > $signed({1'b0, ESCAPE_R2});
  assign in_ready = state == IDLE;
  always_ff @(posedge clock) begin
    if (rst) begin
      state      <= IDLE;
      z_re       <= '0;
      z_im       <= '0;
      cr         <= '0;
      ci         <= '0;
      iter       <= '0;
      mi         <= '0;
      out_count  <= '0;
      out_inside <= 1'b0;
      out_x      <= '0;
      out_y      <= '0;
      out_valid  <= 1'b0;
`ifdef MANDEL_ZOUT_EN
      z_re_out   <= '0;
      z_im_out   <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          cr    <= c_re;
          ci    <= c_im;
          out_x <= px_x;
          out_y <= px_y;
          mi    <= max_iter;
          z_re  <= '0;
          z_im  <= '0;
          iter  <= '0;
          state <= ITER;
        end
        ITER: if (esc || iter == mi) begin
          out_count  <= iter;
          out_inside <= !esc;
          out_valid  <= 1'b1;
`ifdef MANDEL_ZOUT_EN
          z_re_out   <= z_re;
          z_im_out   <= z_im;
`endif
          state      <= DONE;
        end else begin
          z_re <= zr2 - zi2 + cr;
          z_im <= (zri <<< 1) + ci;
          iter <= iter + ITER_W'(1);
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mandel_iter.sv
// tb_mandel_iter: directed self-checking bench for mandel_iter
module tb_mandel_iter;
  logic clock = 1'b0;
  logic rst = 1'b1;
  logic [31:0] c_re = '0, c_im = '0;
  logic [9:0] px_x = '0, px_y = '0;
  logic [7:0] max_iter = '0;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_inside, out_valid;
  logic [7:0] out_count;
  logic [9:0] out_x, out_y;
`ifdef MANDEL_ZOUT_EN
  logic [31:0] z_re_out, z_im_out;
`endif
  int checks = 0;
  int errors = 0;
  mandel_iter #(.ITER_W(8)) dut (
    .clock(clock), .rst(rst), .c_re(c_re), .c_im(c_im), .px_x(px_x), .px_y(px_y),
    .max_iter(max_iter), .in_valid(in_valid), .in_ready(in_ready),
    .out_count(out_count), .out_inside(out_inside), .out_x(out_x), .out_y(out_y),
    .out_valid(out_valid), .out_ready(out_ready)
`ifdef MANDEL_ZOUT_EN
    , .z_re_out(z_re_out), .z_im_out(z_im_out)
`endif
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic job(input logic [31:0] cr, input logic [31:0] ci, input logic [7:0] mi,
                     input logic [9:0] x, input logic [9:0] y, input logic [7:0] ec,
                     input logic ei, input int lat, input int stall);
    int n;
    @(negedge clock);
    c_re = cr; c_im = ci; max_iter = mi; px_x = x; px_y = y; in_valid = 1'b1;
    #1 chk("in_ready_idle", in_ready, 1);
    @(posedge clock);
    #1 in_valid = 1'b0;
    c_re = $urandom; c_im = $urandom; px_x = 10'($urandom); px_y = 10'($urandom); max_iter = 8'($urandom);
    n = 0;
    while (!out_valid && n < 600) begin
      @(posedge clock);
      #1 n++;
    end
    chk("latency", n, lat);
    chk("count", out_count, ec);
    chk("inside", out_inside, ei);
    chk("out_x", out_x, x);
    chk("out_y", out_y, y);
    chk("in_ready_done", in_ready, 0);
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1; c_re = $urandom; px_x = 10'($urandom); max_iter = 8'($urandom);
      @(posedge clock);
      #1 chk("stall_valid", out_valid, 1);
      chk("stall_count", out_count, ec);
      chk("stall_inside", out_inside, ei);
      chk("stall_x", out_x, x);
      chk("stall_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clock);
    #1 out_ready = 1'b0;
    in_valid = 1'b0;
    chk("xfer_valid", out_valid, 0);
    chk("xfer_in_ready", in_ready, 1);
  endtask
  initial begin
    logic seen;
    repeat (3) @(posedge clock);
    #1 chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_count", out_count, 0);
    chk("rst_inside", out_inside, 0);
    chk("rst_x", out_x, 0);
    @(negedge clock) rst = 1'b0;
    job(32'h0000_0000, 32'h0000_0000, 8'd255, 10'd1, 10'd2, 8'd255, 1'b1, 256, 0);
    job(32'h0050_0000, 32'h0000_0000, 8'd255, 10'd3, 10'd4, 8'd1, 1'b0, 2, 0);
    job(32'hFFC0_0000, 32'h0000_0000, 8'd20, 10'd5, 10'd6, 8'd20, 1'b1, 21, 0);
    job(32'h1234_5678, 32'h9ABC_DEF0, 8'd0, 10'd7, 10'd8, 8'd0, 1'b1, 1, 0);
    job(32'h0030_0000, 32'h0020_0000, 8'd255, 10'd9, 10'd10, 8'd2, 1'b0, 3, 5);
    job(32'h0000_0000, 32'h0020_0000, 8'd10, 10'd11, 10'd12, 8'd10, 1'b1, 11, 0);
    job(32'h0020_0000, 32'h0000_0000, 8'd255, 10'd13, 10'd14, 8'd3, 1'b0, 4, 0);
    @(negedge clock);
    c_re = '0; c_im = '0; max_iter = 8'd100; px_x = 10'd7; px_y = 10'd9; in_valid = 1'b1;
    @(posedge clock);
    #1 in_valid = 1'b0;
    repeat (10) @(posedge clock);
    @(negedge clock) rst = 1'b1;
    @(posedge clock);
    #1 rst = 1'b0;
    chk("rel_in_ready", in_ready, 1);
    chk("rel_out_valid", out_valid, 0);
    chk("rel_x", out_x, 0);
    chk("rel_y", out_y, 0);
    seen = 1'b0;
    repeat (120) begin
      @(posedge clock);
      #1 if (out_valid) seen = 1'b1;
    end
    chk("no_valid_after_rst", seen, 0);
    job(32'h0020_0000, 32'h0000_0000, 8'd2, 10'd15, 10'd16, 8'd2, 1'b1, 3, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
